// File: rtl/time_surface_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module   : time_surface_scan_controller
//  Purpose  : Sweeps every cell of the exponential time-surface encoder and
//             streams the returned decay values out as valid/ready beats.
//             A scan starts on a start pulse or on the periodic auto trigger.
//             Reads are paced by credits so the small output FIFO never
//             overflows while downstream applies backpressure.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             start, auto_en      - scan request / periodic trigger enable
//             ts_read_*           - encoder read port (enable, addr, value)
//             feat_*              - output stream (valid, ready, data, addr,
//                                   last)
//             busy, done, overrun - status: scanning, end pulse, dropped
//                                   trigger pulse
//  Revision : 1.0 - initial release
// ============================================================================
module time_surface_scan_controller #(
    parameter int GRID_SIZE     = 16,
    parameter int ADDR_BITS     = 8,
    parameter int VALUE_BITS    = 8,
    parameter int READ_LATENCY  = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int PERIOD_CYCLES = 65536
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  auto_en,
    output logic                  ts_read_enable,
    output logic [ADDR_BITS-1:0]  ts_read_addr,
    input  logic [VALUE_BITS-1:0] ts_read_value,
    output logic                  feat_valid,
    input  logic                  feat_ready,
    output logic [VALUE_BITS-1:0] feat_data,
    output logic [ADDR_BITS-1:0]  feat_addr,
    output logic                  feat_last,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int c_NUM_CELLS = GRID_SIZE * GRID_SIZE;
    localparam logic [ADDR_BITS-1:0] c_LAST_ADDR = ADDR_BITS'(c_NUM_CELLS - 1);
    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_PER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int c_CR_W  = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;
    localparam logic [c_PER_W-1:0] c_PERIOD_LAST = c_PER_W'(PERIOD_CYCLES - 1);
    localparam logic [c_CR_W-1:0]  c_DEPTH_CR    = c_CR_W'(FIFO_DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SCAN  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [c_PER_W-1:0]      r_period_cnt;
    logic [ADDR_BITS-1:0]    r_issue_addr;
    logic [ADDR_BITS-1:0]    r_last_addr;
    logic [READ_LATENCY-1:0] r_tag_v;
    logic [ADDR_BITS-1:0]    r_tag_addr [READ_LATENCY];
    logic [VALUE_BITS-1:0]   r_mem_data [FIFO_DEPTH];
    logic [ADDR_BITS-1:0]    r_mem_addr [FIFO_DEPTH];
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_CNT_W-1:0]      r_count;
    logic                    r_done;

    logic                    w_trigger;
    logic                    w_pop;
    logic                    w_push;
    logic [c_CR_W-1:0]       w_inflight;
    logic [c_CR_W-1:0]       w_occ;
    logic                    w_issue;
    logic                    w_drain_done;

    assign w_trigger = start | (auto_en & (r_period_cnt == c_PERIOD_LAST));
    assign w_pop     = (r_count != '0) & feat_ready;
    assign w_push    = r_tag_v[READ_LATENCY-1];

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_inflight = w_inflight + c_CR_W'(r_tag_v[i]);
        end
    end

    // Occupancy excludes the entry leaving this cycle so a pop frees its
    // credit immediately and full-rate streaming needs no extra slack.
    assign w_occ        = c_CR_W'(r_count) - c_CR_W'(w_pop);
    assign w_issue      = (r_state == c_ST_SCAN) && ((w_occ + w_inflight) < c_DEPTH_CR);
    assign w_drain_done = (w_inflight == '0) && (w_occ == '0);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_trigger) w_state_next = c_ST_SCAN;
            end
            c_ST_SCAN: begin
                if (w_issue && (r_issue_addr == c_LAST_ADDR)) w_state_next = c_ST_DRAIN;
            end
            c_ST_DRAIN: begin
                if (w_drain_done) w_state_next = c_ST_IDLE;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        ts_read_enable = (r_state != c_ST_IDLE);
        busy           = (r_state != c_ST_IDLE);
        overrun        = w_trigger && (r_state != c_ST_IDLE);
        done           = r_done;
        // On a stall the last issued address is re-presented; the encoder
        // read is side-effect free and keeps its pipeline moving.
        ts_read_addr   = '0;
        if (w_issue) begin
            ts_read_addr = r_issue_addr;
        end else if (r_state != c_ST_IDLE) begin
            ts_read_addr = r_last_addr;
        end
    end

    // ---------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_cnt <= '0;
            r_issue_addr <= '0;
            r_last_addr  <= '0;
            r_tag_v      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_done       <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_tag_addr[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_addr[i] <= '0;
            end
        end else begin
            if (!auto_en) begin
                r_period_cnt <= '0;
            end else if (r_period_cnt == c_PERIOD_LAST) begin
                r_period_cnt <= '0;
            end else begin
                r_period_cnt <= r_period_cnt + 1'b1;
            end

            if ((r_state == c_ST_IDLE) && w_trigger) begin
                r_issue_addr <= '0;
                r_last_addr  <= '0;
            end else if (w_issue) begin
                r_last_addr <= r_issue_addr;
                // Terminal address is not incremented so it never wraps.
                if (r_issue_addr != c_LAST_ADDR) begin
                    r_issue_addr <= r_issue_addr + 1'b1;
                end
            end

            // Tag pipeline mirrors the encoder read latency; a set tag at the
            // tail marks the cycle its value is present on ts_read_value.
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                r_tag_v[i]    <= r_tag_v[i-1];
                r_tag_addr[i] <= r_tag_addr[i-1];
            end
            r_tag_v[0]    <= w_issue;
            r_tag_addr[0] <= r_issue_addr;

            if (w_push) begin
                r_mem_data[r_wr_ptr] <= ts_read_value;
                r_mem_addr[r_wr_ptr] <= r_tag_addr[READ_LATENCY-1];
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

            r_done <= (r_state == c_ST_DRAIN) && w_drain_done;
        end
    end

    // The stream head is read straight from the FIFO storage registers, so
    // it stays stable while the beat is held off by backpressure.
    always_comb begin
        feat_valid = (r_count != '0);
        feat_data  = '0;
        feat_addr  = '0;
        feat_last  = 1'b0;
        if (feat_valid) begin
            feat_data = r_mem_data[r_rd_ptr];
            feat_addr = r_mem_addr[r_rd_ptr];
            feat_last = (r_mem_addr[r_rd_ptr] == c_LAST_ADDR);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_time_surface_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_time_surface_scan_controller
//  Purpose  : Self-checking bench for time_surface_scan_controller. Drives a
//             two-cycle encoder model and compares the stream, status and read
//             port against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_time_surface_scan_controller;

    localparam int P_PERIOD = 300;
    localparam int N        = 256;
    localparam int DEPTH    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       auto_en = 1'b0;
    logic       feat_ready = 1'b0;
    logic       ts_read_enable;
    logic [7:0] ts_read_addr;
    logic [7:0] ts_read_value;
    logic       feat_valid;
    logic [7:0] feat_data;
    logic [7:0] feat_addr;
    logic       feat_last;
    logic       busy;
    logic       done;
    logic       overrun;

    time_surface_scan_controller #(
        .GRID_SIZE(16), .ADDR_BITS(8), .VALUE_BITS(8),
        .READ_LATENCY(2), .FIFO_DEPTH(DEPTH), .PERIOD_CYCLES(P_PERIOD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .auto_en(auto_en),
        .ts_read_enable(ts_read_enable), .ts_read_addr(ts_read_addr),
        .ts_read_value(ts_read_value), .feat_valid(feat_valid),
        .feat_ready(feat_ready), .feat_data(feat_data), .feat_addr(feat_addr),
        .feat_last(feat_last), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Encoder: value = addr ^ 0x5A ^ salt, two cycles after the read.
    logic [7:0] salt = 8'h00;
    logic [7:0] enc_p1 = 8'h00;
    logic [7:0] enc_p2 = 8'h00;
    always @(posedge clk) begin
        enc_p1 <= ts_read_addr ^ 8'h5A ^ salt;
        enc_p2 <= enc_p1;
    end
    assign ts_read_value = enc_p2;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model state
    bit   m_busy = 0, m_done = 0, m_stall_prev = 0;
    int   m_pc = 0, m_exp = 0, m_acc = 0, m_prev_raddr = 0;
    logic [7:0] h_data, h_addr;
    logic h_last;

    // Observation records
    bit   prev_busy_obs = 0, saw_done = 0;
    int   n_done = 0, n_overrun = 0;
    int   first_valid_cyc = -1, last_beat_cyc = -1, done_cyc = -1;
    int   fall_cyc = -1, overrun_cyc = -1;
    int   rise_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check();
        logic       trig, acc, acc_last;
        logic [7:0] ed;
        int         d;
        trig = start | (auto_en & (m_pc == P_PERIOD - 1));
        acc  = feat_valid & feat_ready;
        acc_last = 1'b0;
        if (rst) begin
            m_busy = 0; m_done = 0; m_pc = 0; m_stall_prev = 0; prev_busy_obs = 0;
            return;
        end
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("rd_en", ts_read_enable, m_busy);
        chk("overrun", overrun, trig & m_busy);
        if (!m_busy) chk("idle_valid", feat_valid, 0);
        if (m_stall_prev) begin
            chk("hold_valid", feat_valid, 1);
            chk("hold_data", feat_data, h_data);
            chk("hold_addr", feat_addr, h_addr);
            chk("hold_last", feat_last, h_last);
        end
        if (acc) begin
            ed = 8'(m_exp) ^ 8'h5A ^ salt;
            chk("beat_addr", feat_addr, m_exp);
            chk("beat_data", feat_data, ed);
            chk("beat_last", feat_last, m_exp == N - 1);
            acc_last = (m_exp == N - 1);
        end
        if (m_busy) begin
            d = int'(ts_read_addr) - m_prev_raddr;
            chk("raddr_step", (d == 0 || d == 1), 1);
            chk("credit", (int'(ts_read_addr) + 1 - (m_acc + (acc ? 1 : 0))) <= DEPTH, 1);
            m_prev_raddr = int'(ts_read_addr);
        end
        // observations
        if (feat_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (busy && !prev_busy_obs) rise_cyc.push_back(cyc);
        if (!busy && prev_busy_obs) fall_cyc = cyc;
        prev_busy_obs = busy;
        if (done) begin n_done++; done_cyc = cyc; saw_done = 1; end
        if (overrun) begin n_overrun++; overrun_cyc = cyc; end
        if (acc_last) last_beat_cyc = cyc;
        // model advance
        if (acc) begin m_exp++; m_acc++; end
        m_done = acc_last;
        if (!m_busy && trig) begin
            m_busy = 1; m_exp = 0; m_acc = 0; m_prev_raddr = 0; first_valid_cyc = -1;
        end else if (acc_last) begin
            m_busy = 0;
        end
        m_stall_prev = feat_valid & !feat_ready;
        h_data = feat_data; h_addr = feat_addr; h_last = feat_last;
        m_pc = auto_en ? ((m_pc == P_PERIOD - 1) ? 0 : m_pc + 1) : 0;
    endtask

    task automatic cycle();
        #2;
        check();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_all_zero(input string tag);
        #1;
        chk({tag, "_rd_en"}, ts_read_enable, 0);
        chk({tag, "_rd_addr"}, ts_read_addr, 0);
        chk({tag, "_valid"}, feat_valid, 0);
        chk({tag, "_data"}, feat_data, 0);
        chk({tag, "_addr"}, feat_addr, 0);
        chk({tag, "_last"}, feat_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    // mode 0: ready always 1; mode 1: ready low 1-in-3 plus a hold-low window
    task automatic run_until_done(input int s, input int budget, input int mode,
                                  input int hold_from, input int hold_len, input int restart_at);
        int rel;
        saw_done = 0;
        for (int i = 0; i < budget && !saw_done; i++) begin
            rel = cyc - s;
            if (mode == 0) feat_ready = 1'b1;
            else if (rel >= hold_from && rel < hold_from + hold_len) feat_ready = 1'b0;
            else feat_ready = ($urandom_range(0, 2) != 0);
            start = (rel == restart_at);
            cycle();
        end
        start = 1'b0;
        chk("scan_completed", saw_done, 1);
    endtask

    function automatic int rise_at(input int idx);
        if (idx < rise_cyc.size()) return rise_cyc[idx];
        return -1;
    endfunction

    initial begin
        int s, t0, d0, o0, r0;
        @(posedge clk);
        #1;
        repeat (3) cycle();
        rst = 1'b0;
        chk_all_zero("reset");
        cycle();
        repeat (4) cycle();

        // 1: single scan at full rate, absolute timing
        salt = 8'h00;
        s = cyc; d0 = n_done;
        start = 1'b1; feat_ready = 1'b1; cycle(); start = 1'b0;
        run_until_done(s, 600, 0, 0, 0, -1);
        chk("t1_issue_cyc", rise_at(rise_cyc.size() - 1), s + 1);
        chk("t1_first_valid", first_valid_cyc, s + 4);
        chk("t1_last_beat", last_beat_cyc, s + 259);
        chk("t1_done_cyc", done_cyc, s + 260);
        chk("t1_busy_fall", fall_cyc, s + 260);
        chk("t1_beats", m_acc, N);
        chk("t1_done_count", n_done - d0, 1);
        repeat (5) cycle();

        // 2: random backpressure plus a long stall
        salt = 8'($urandom);
        s = cyc; d0 = n_done;
        start = 1'b1; cycle(); start = 1'b0;
        run_until_done(s, 3000, 1, 80, 50, -1);
        chk("t2_beats", m_acc, N);
        chk("t2_done_count", n_done - d0, 1);
        feat_ready = 1'b1;
        repeat (5) cycle();

        // 3: second start mid-scan is dropped with an overrun pulse
        salt = 8'($urandom);
        s = cyc; d0 = n_done; o0 = n_overrun; r0 = rise_cyc.size();
        start = 1'b1; cycle(); start = 1'b0;
        run_until_done(s, 600, 0, 0, 0, 100);
        repeat (20) cycle();
        chk("t3_overrun_cyc", overrun_cyc, s + 100);
        chk("t3_overrun_count", n_overrun - o0, 1);
        chk("t3_done_count", n_done - d0, 1);
        chk("t3_scans", rise_cyc.size() - r0, 1);

        // 5: reset mid-scan under backpressure, then a fresh scan
        s = cyc; d0 = n_done;
        feat_ready = 1'b0;
        start = 1'b1; cycle(); start = 1'b0;
        while (cyc < s + 150) cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        chk_all_zero("t5_post_rst");
        while (cyc < s + 160) cycle();
        feat_ready = 1'b1;
        start = 1'b1; cycle(); start = 1'b0;
        #1;
        chk("t5_restart_addr", ts_read_addr, 0);
        chk("t5_restart_en", ts_read_enable, 1);
        run_until_done(s + 160, 600, 0, 0, 0, -1);
        chk("t5_beats", m_acc, N);
        chk("t5_done_count", n_done - d0, 1);
        repeat (5) cycle();

        // 4 + 6: periodic triggers, third one coincides with start
        salt = 8'($urandom);
        feat_ready = 1'b1;
        t0 = cyc; d0 = n_done; o0 = n_overrun; r0 = rise_cyc.size();
        auto_en = 1'b1;
        while (cyc < t0 + 1180) begin
            start = (cyc == t0 + 899);
            cycle();
        end
        start = 1'b0; auto_en = 1'b0;
        repeat (5) cycle();
        chk("t4_scan1_start", rise_at(r0), t0 + 300);
        chk("t4_scan2_start", rise_at(r0 + 1), t0 + 600);
        chk("t6_scan3_start", rise_at(r0 + 2), t0 + 900);
        chk("t4_scans", rise_cyc.size() - r0, 3);
        chk("t4_done_count", n_done - d0, 3);
        chk("t4_overruns", n_overrun - o0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
